mem_responder: RTL

Pipelined main-memory model that answers block fills and write-throughs from the instruction and data caches. It sits on the memory side of the cache bus: it accepts one read or write per cycle, returns each read word a fixed LATENCY cycles later with a one-cycle valid strobe, and commits writes at the accepting edge. It is sized and timed so that the cache fill FSM can stream 8 consecutive word addresses and receive 8 back-to-back valid words.

---
 rtl/mem_responder.sv | 97 +++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: pipelined word-array memory model for the cache bus.
// Accepts one read or write per cycle with no back-pressure. Writes commit
// at the accepting edge. Read data is captured at the accepting edge and
// returned LATENCY cycles later with a one-cycle data_valid strobe.
module mem_responder #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned ADDR_W  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        busy,
  output logic [3:0]  outstanding
);

  // Word array. It has no reset: contents survive rst.
  logic [15:0] mem_q [2**ADDR_W];

  logic [ADDR_W-1:0] word_idx;
  logic              rd_acc;
  logic              mem_we;
  logic              unused_addr_lsb;

  // Return pipeline. Stage LATENCY-1 drives the outputs.
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [15:0]        dat_q [LATENCY];
  logic [15:0]        dat_d [LATENCY];
  logic [3:0]         outst_q, outst_d;

  assign word_idx        = addr[ADDR_W:1];
  assign unused_addr_lsb = addr[0];

  // Decode the request. A write is blocked while rst is low, so a write
  // coinciding with reset is never committed.
  always_comb begin
    rd_acc = enable & ~wr;
    mem_we = enable & wr & rst;
  end

  // Pipeline next state. A stage loads data only when a valid word enters
  // it, so the last stage (data_out) holds its last returned value across
  // bubbles.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = rd_acc;
    dat_d[0] = rd_acc ? mem_q[word_idx] : dat_q[0];
    for (int unsigned i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
    end
  end

  // In-flight read count: up on accept, down on retire, held when both.
  always_comb begin
    outst_d = outst_q;
    unique case ({rd_acc, vld_q[LATENCY-1]})
      2'b10:   outst_d = outst_q + 4'd1;
      2'b01:   outst_d = outst_q - 4'd1;
      default: outst_d = outst_q;
    endcase
  end

  // Pipeline and counter registers; reset drops every in-flight read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q   <= '0;
      outst_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q   <= vld_d;
      outst_q <= outst_d;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  // Array write port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[word_idx] <= data_in;
    end
  end

  assign data_valid  = vld_q[LATENCY-1];
  assign data_out    = dat_q[LATENCY-1];
  assign outstanding = outst_q;
  assign busy        = (outst_q != 4'd0);

endmodule
